// File: rtl/seq_pingpong_buffer_pkg.sv
// Shared sizing, letter encodings and bank-state type for the ping-pong sequence buffer.
// The buffer slices a 32-letter DNA sequence into bytes of four 2-bit letters.
package seq_pingpong_buffer_pkg;

  localparam int SEQ_LENGTH       = 32;
  localparam int LETTER_WIDTH     = 2;
  localparam int INPUT_WIDTH      = 8;
  localparam int SEQ_BUS_W        = SEQ_LENGTH * LETTER_WIDTH;
  localparam int NUM_BUFF_REGS    = SEQ_BUS_W / INPUT_WIDTH;
  localparam int LETTERS_PER_BYTE = INPUT_WIDTH / LETTER_WIDTH;
  localparam int IDX_W            = $clog2(NUM_BUFF_REGS);

  localparam logic [LETTER_WIDTH-1:0] LETTER_A = 2'b00;
  localparam logic [LETTER_WIDTH-1:0] LETTER_T = 2'b01;
  localparam logic [LETTER_WIDTH-1:0] LETTER_C = 2'b10;
  localparam logic [LETTER_WIDTH-1:0] LETTER_G = 2'b11;

  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_t;

  function automatic logic [1:0] full_count(input bank_state_t b0, input bank_state_t b1);
    return {1'b0, b0 == BANK_FULL} + {1'b0, b1 == BANK_FULL};
  endfunction

endpackage

// File: rtl/seq_bank.sv
// One sequence bank: byte-addressed write port, whole sequence presented as a flat bus.
module seq_bank
  import seq_pingpong_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [INPUT_WIDTH-1:0] wr_data,
  output logic [SEQ_BUS_W-1:0]   rd_data
);

  logic [INPUT_WIDTH-1:0] regs [NUM_BUFF_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUFF_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Byte j lands at bits [8j+7:8j], which puts letter k at bits [2k+1:2k].
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BUFF_REGS; i++) rd_data[i*INPUT_WIDTH +: INPUT_WIDTH] = regs[i];
  end

endmodule

// File: rtl/seq_pingpong_buffer.sv
// Two-bank ping-pong feeder: loads the next sequence byte-wise while the PUs score the
// current one, which is held on a parallel bus until the consumer releases it.
module seq_pingpong_buffer
  import seq_pingpong_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_data,
  output logic                   seq_valid,
  output logic [SEQ_BUS_W-1:0]   seq_letters,
  input  logic                   seq_release,
  output logic [1:0]             level,
  output logic                   rd_bank
);

  bank_state_t          bank_st [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [IDX_W-1:0]     wr_cnt;
  logic                 accept;
  logic                 release_ok;
  logic                 last_byte;
  logic [SEQ_BUS_W-1:0] bank_data [2];

  assign in_ready   = (bank_st[wr_ptr] == BANK_EMPTY) && !flush;
  assign seq_valid  = (bank_st[rd_ptr] == BANK_FULL);
  assign accept     = in_valid && in_ready;
  assign release_ok = seq_release && seq_valid && !flush;
  assign last_byte  = (wr_cnt == IDX_W'(NUM_BUFF_REGS - 1));

  // Write and release never hit the same bank: one needs EMPTY, the other FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_cnt     <= '0;
    end else if (flush) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_cnt     <= '0;
    end else begin
      if (accept) begin
        if (last_byte) begin
          bank_st[wr_ptr] <= BANK_FULL;
          wr_ptr          <= ~wr_ptr;
          wr_cnt          <= '0;
        end else begin
          wr_cnt <= wr_cnt + IDX_W'(1);
        end
      end
      if (release_ok) begin
        bank_st[rd_ptr] <= BANK_EMPTY;
        rd_ptr          <= ~rd_ptr;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    seq_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept && (wr_ptr == 1'(b))),
      .wr_idx  (wr_cnt),
      .wr_data (in_data),
      .rd_data (bank_data[b])
    );
  end

  // Both mux inputs and the select are registers, so seq_* never sees in_* combinationally.
  assign seq_letters = bank_data[rd_ptr];
  assign level       = full_count(bank_st[0], bank_st[1]);
  assign rd_bank     = rd_ptr;

endmodule
